// File: rtl/slave_to_master_mux_if.sv
// Bus bundle between the slave side of an AHB-style fabric and the response mux.
// The master modport drives address-phase controls and per-slave responses; the slave modport is the mux.
`ifndef NUM_SLAVES
`define NUM_SLAVES 4
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

interface slave_to_master_mux_if #(
  parameter int NUM_SLAVES = `NUM_SLAVES,
  parameter int DATA_WIDTH = `DATA_WIDTH
);
  logic [NUM_SLAVES-1:0]                 Hsel;
  logic [1:0]                            Htrans;
  logic [NUM_SLAVES-1:0][DATA_WIDTH-1:0] Hrdata_S;
  logic [NUM_SLAVES-1:0]                 Hreadyout_S;
  logic [NUM_SLAVES-1:0]                 Hresp_S;
  logic [DATA_WIDTH-1:0]                 Hrdata;
  logic                                  Hready;
  logic                                  Hresp;

  modport master (
    output Hsel, Htrans, Hrdata_S, Hreadyout_S, Hresp_S,
    input  Hrdata, Hready, Hresp
  );

  modport slave (
    input  Hsel, Htrans, Hrdata_S, Hreadyout_S, Hresp_S,
    output Hrdata, Hready, Hresp
  );
endinterface

// File: rtl/slave_to_master_mux.sv
// Slave-to-master response mux with a built-in default slave that answers
// unmapped or multi-hot selects with a two-cycle ERROR response.
`ifndef NUM_SLAVES
`define NUM_SLAVES 4
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module slave_to_master_mux #(
  parameter int NUM_SLAVES = `NUM_SLAVES,
  parameter int DATA_WIDTH = `DATA_WIDTH
) (
  input  logic                  Hclk,
  input  logic                  Hreset,
  slave_to_master_mux_if.slave  bus
);

  localparam int              SEL_W  = $clog2(NUM_SLAVES + 1);
  localparam logic [SEL_W-1:0] DS_SEL = SEL_W'(NUM_SLAVES);

  typedef enum logic [1:0] {
    DS_IDLE,
    DS_ERR1,
    DS_ERR2
  } ds_state_e;

  logic [SEL_W-1:0]      sel_q, sel_d;
  ds_state_e             ds_q, ds_d;
  logic [SEL_W-1:0]      addr_sel;
  logic                  any_hot;
  logic                  multi_hot;
  logic                  addr_to_ds;
  logic                  addr_active;
  logic [DATA_WIDTH-1:0] rdata_mux;
  logic                  ready_mux;
  logic                  resp_mux;

  // Address-phase decode: anything other than exactly one select bit goes to the default slave.
  always_comb begin
    any_hot   = 1'b0;
    multi_hot = 1'b0;
    addr_sel  = DS_SEL;
    for (int k = 0; k < NUM_SLAVES; k++) begin
      if (bus.Hsel[k]) begin
        multi_hot = multi_hot | any_hot;
        any_hot   = 1'b1;
        addr_sel  = SEL_W'(k);
      end
    end
    addr_to_ds = !any_hot || multi_hot;
    if (addr_to_ds) begin
      addr_sel = DS_SEL;
    end
  end

  assign addr_active = bus.Htrans[1];

  always_comb begin
    rdata_mux = '0;
    ready_mux = 1'b1;
    resp_mux  = 1'b0;
    if (sel_q == DS_SEL) begin
      ready_mux = (ds_q != DS_ERR1);
      resp_mux  = (ds_q != DS_IDLE);
    end else begin
      for (int k = 0; k < NUM_SLAVES; k++) begin
        if (sel_q == SEL_W'(k)) begin
          rdata_mux = bus.Hrdata_S[k];
          ready_mux = bus.Hreadyout_S[k];
          resp_mux  = bus.Hresp_S[k];
        end
      end
    end
  end

  assign bus.Hrdata = rdata_mux;
  assign bus.Hready = ready_mux;
  assign bus.Hresp  = resp_mux;

  // ERR1 is the only state that advances while Hready is low; everything else waits for Hready.
  always_comb begin
    sel_d = sel_q;
    ds_d  = ds_q;
    case (ds_q)
      DS_ERR1: ds_d = DS_ERR2;
      default: begin
        if (ready_mux) begin
          sel_d = addr_sel;
          ds_d  = (addr_to_ds && addr_active) ? DS_ERR1 : DS_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge Hclk or posedge Hreset) begin
    if (Hreset) begin
      sel_q <= DS_SEL;
      ds_q  <= DS_IDLE;
    end else begin
      sel_q <= sel_d;
      ds_q  <= ds_d;
    end
  end

endmodule
